l2_mem_responder: RTL

L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

---
 rtl/l2_mem_responder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/l2_mem_responder.sv
// l2_mem_responder: single-outstanding-request line memory behind an L2.
// A request is accepted from IDLE, held for LATENCY cycles, then answered
// with a one-cycle response pulse. Loads read the line in the last BUSY
// cycle; stores write the line in the RESPOND cycle. RAM is never reset.
module l2_mem_responder #(
    parameter int unsigned LG_LINES = 8,
    parameter int unsigned LATENCY  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_req_valid,
    input  logic [31:0]  mem_req_addr,
    input  logic [511:0] mem_req_store_data,
    input  logic [3:0]   mem_req_opcode,
    output logic         mem_req_ack,
    output logic         mem_rsp_valid,
    output logic [511:0] mem_rsp_load_data,
    output logic         mem_rsp_error
);

    localparam int unsigned Lines   = 1 << LG_LINES;
    localparam logic [3:0]  OpLoad  = 4'd4;
    localparam logic [3:0]  OpStore = 4'd7;
    // Counter starts at LATENCY-1 so the response lands LATENCY cycles after ack.
    localparam logic [7:0]  CntInit = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StRespond,
        StCooldown
    } state_e;

    state_e              state_q;
    logic [7:0]          cnt_q;
    logic [LG_LINES-1:0] idx_q;
    logic [3:0]          op_q;
    logic [511:0]        wdata_q;
    logic                ack_q;
    logic                rsp_valid_q;
    logic                rsp_error_q;
    logic [511:0]        rsp_data_q;

    logic [511:0]        ram [Lines];
    logic [511:0]        ram_rdata;
    logic                ram_we;
    logic                op_is_load;
    logic                op_is_store;

    // Offset bits and bits above the index are don't-care (addresses alias).
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{mem_req_addr[5:0], mem_req_addr[31:LG_LINES+6]};

    // Decode the latched opcode and RAM port controls.
    always_comb begin
        op_is_load  = (op_q == OpLoad);
        op_is_store = (op_q == OpStore);
        ram_rdata   = ram[idx_q];
        ram_we      = (state_q == StRespond) && op_is_store;
    end

    // Line storage: written only in the RESPOND cycle of a store, never reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx_q] <= wdata_q;
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            idx_q       <= '0;
            op_q        <= 4'd0;
            wdata_q     <= '0;
            ack_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mem_req_valid) begin
                        idx_q   <= mem_req_addr[LG_LINES+5:6];
                        op_q    <= mem_req_opcode;
                        wdata_q <= mem_req_store_data;
                        ack_q   <= 1'b1;
                        cnt_q   <= CntInit;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q == 8'd0) begin
                        state_q     <= StRespond;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= !(op_is_load || op_is_store);
                        rsp_data_q  <= op_is_load ? ram_rdata : '0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                StRespond: begin
                    rsp_valid_q <= 1'b0;
                    rsp_error_q <= 1'b0;
                    rsp_data_q  <= '0;
                    state_q     <= StCooldown;
                end
                StCooldown: begin
                    // The L2 still holds valid here; it must not start a new request.
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_req_ack       = ack_q;
    assign mem_rsp_valid     = rsp_valid_q;
    assign mem_rsp_error     = rsp_error_q;
    assign mem_rsp_load_data = rsp_data_q;

endmodule
